// File: rtl/loader_pkg.sv
// loader_pkg: shared state encoding, sync byte and frame field positions for the program loader
package loader_pkg;
  typedef enum logic [3:0] {
    S_IDLE, S_ADDR_HI, S_ADDR_LO, S_CNT_HI, S_CNT_LO, S_DATA, S_CSUM, S_RUN, S_ERROR
  } loader_state_t;
  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam int F_SYNC    = 0;
  localparam int F_ADDR_HI = 1;
  localparam int F_ADDR_LO = 2;
  localparam int F_CNT_HI  = 3;
  localparam int F_CNT_LO  = 4;
  localparam int F_DATA    = 5;
endpackage

// File: rtl/byte_word_packer.sv
// byte_word_packer: shifts big-endian bytes into a word and pulses word_valid_o the cycle after the last byte
module byte_word_packer #(
  parameter int BYTES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr_i,
  input  logic               byte_valid_i,
  input  logic [7:0]         byte_i,
  output logic               last_o,
  output logic               word_valid_o,
  output logic [BYTES*8-1:0] word_o
);
  localparam int W  = BYTES * 8;
  localparam int CW = BYTES > 1 ? $clog2(BYTES) : 1;
  logic [CW-1:0] cnt_q;
  logic [W-1:0]  sh_q, sh_d, word_q;
  logic          valid_q;
  assign last_o       = cnt_q == CW'(BYTES - 1);
  assign sh_d         = (sh_q << 8) | W'(byte_i);
  assign word_valid_o = valid_q;
  assign word_o       = word_q;
  // word_q only changes on a completed word so the memory data port holds between writes
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q   <= '0;
      sh_q    <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= byte_valid_i && last_o && !clr_i;
      if (clr_i) begin
        cnt_q <= '0;
        sh_q  <= '0;
      end else if (byte_valid_i) begin
        sh_q  <= sh_d;
        cnt_q <= last_o ? '0 : cnt_q + CW'(1);
        if (last_o) word_q <= sh_d;
      end
    end
  end
endmodule

// File: rtl/program_loader.sv
// program_loader: boot loader that writes a checksummed byte-stream frame into memory and then releases the core
module program_loader
  import loader_pkg::*;
#(
  parameter int         ADDR_W = 13,
  parameter int         WORD_W = 16,
  parameter logic [7:0] SYNC   = SYNC_BYTE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              load_active,
  output logic              core_rst,
  output logic              load_done,
  output logic              load_err
);
  localparam int BYTES = WORD_W / 8;
  loader_state_t     state_q;
  logic [ADDR_W-1:0] addr_q, mem_addr_q;
  logic [15:0]       cnt_q;
  logic [7:0]        hdr_q, csum_q;
  logic              run_q, done_q, err_q, last;
  byte_word_packer #(.BYTES(BYTES)) u_packer (
    .clk         (clk),
    .rst         (rst),
    .clr_i       (state_q != S_DATA),
    .byte_valid_i(in_valid && state_q == S_DATA),
    .byte_i      (in_data),
    .last_o      (last),
    .word_valid_o(mem_we),
    .word_o      (mem_wdata)
  );
  assign in_ready    = 1'b1;
  assign mem_addr    = mem_addr_q;
  assign core_rst    = ~run_q;
  assign load_active = ~run_q;
  assign load_done   = done_q;
  assign load_err    = err_q;
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      mem_addr_q <= '0;
      cnt_q      <= '0;
      hdr_q      <= '0;
      csum_q     <= '0;
      run_q      <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (in_valid) begin
        case (state_q)
          S_IDLE, S_RUN, S_ERROR: if (in_data == SYNC) begin
            state_q <= S_ADDR_HI;
            csum_q  <= '0;
            run_q   <= 1'b0;
            err_q   <= 1'b0;
          end
          S_ADDR_HI: begin
            hdr_q   <= in_data;
            csum_q  <= csum_q ^ in_data;
            state_q <= S_ADDR_LO;
          end
          S_ADDR_LO: begin
            addr_q  <= ADDR_W'({hdr_q, in_data});
            csum_q  <= csum_q ^ in_data;
            state_q <= S_CNT_HI;
          end
          S_CNT_HI: begin
            hdr_q   <= in_data;
            csum_q  <= csum_q ^ in_data;
            state_q <= S_CNT_LO;
          end
          S_CNT_LO: begin
            cnt_q   <= {hdr_q, in_data};
            csum_q  <= csum_q ^ in_data;
            state_q <= {hdr_q, in_data} == 16'd0 ? S_CSUM : S_DATA;
          end
          S_DATA: begin
            csum_q <= csum_q ^ in_data;
            // the packer writes next cycle; latch this word's address before advancing
            if (last) begin
              mem_addr_q <= addr_q;
              addr_q     <= addr_q + ADDR_W'(1);
              cnt_q      <= cnt_q - 16'd1;
              if (cnt_q == 16'd1) state_q <= S_CSUM;
            end
          end
          S_CSUM: begin
            state_q <= in_data == csum_q ? S_RUN : S_ERROR;
            run_q   <= in_data == csum_q;
            done_q  <= in_data == csum_q;
            err_q   <= in_data != csum_q;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end
endmodule
